// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: request/acknowledge memory bus between the control unit and
// the RAM controller.
//   req     master->slave  request strobe
//   we      master->slave  1 = store, 0 = load
//   addr    master->slave  word address
//   wdata   master->slave  store data
//   busy    slave->master  controller not idle
//   ack     slave->master  one-cycle completion pulse
//   rdata   slave->master  last load result
//   out_val slave->master  memory-mapped output register
interface ram_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  busy;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] out_val;

    modport master (
        output req, we, addr, wdata,
        input  busy, ack, rdata, out_val
    );

    modport slave (
        input  req, we, addr, wdata,
        output busy, ack, rdata, out_val
    );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port RAM with request/acknowledge handshake, configurable
// wait states and a memory-mapped output register.
//   clk    system clock, all state changes on the rising edge
//   reset  asynchronous, active-low reset
//   bus    ram_ctrl_if slave port (req/we/addr/wdata in; busy/ack/rdata/out_val out)
// Operands are latched on acceptance; a request is only sampled in IDLE.
// The storage array mem is not reset and may be preloaded hierarchically.
module ram_ctrl #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned OUT_ADDR    = 2**ADDR_WIDTH - 1
) (
  input logic       clk,
  input logic       reset,
  ram_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : '0;
  localparam logic [ADDR_WIDTH-1:0] OUT_A = ADDR_WIDTH'(OUT_ADDR);

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, ACK} state_t;

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  busy_q;
  logic                  ack_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] out_q;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Kept outside the reset block so the array carries no reset. An
  // asserted reset forces state to IDLE, so an uncommitted store never
  // reaches this write.
  always_ff @(posedge clk) begin
    if (state == COMMIT && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      out_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          ack_q <= 1'b0;
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            busy_q  <= 1'b1;
            if (WAIT_STATES > 0) begin
              wait_cnt <= WAIT_LOAD;
              state    <= WAIT;
            end else begin
              state <= COMMIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= COMMIT;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        COMMIT: begin
          if (we_q) begin
            if (addr_q == OUT_A) begin
              out_q <= wdata_q;
            end
          end else begin
            rdata_q <= mem[addr_q];
          end
          ack_q <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          ack_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          ack_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.ack     = ack_q;
  assign bus.rdata   = rdata_q;
  assign bus.out_val = out_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: self-checking bench for ram_ctrl. Four controllers share clk
// and reset: k=0 (8x16, W=0), k=1 (8x16, W=3), k=2 (8x16, W=2) and
// k=3 (16x256, W=1, output register at 0x80). A directed table, a mid-WAIT
// reset sequence and a randomized run are checked against an array model.
module tb_ram_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // shared per-instance stimulus and observation arrays (16-bit wide)
    logic        req_s   [4];
    logic        we_s    [4];
    logic [7:0]  addr_s  [4];
    logic [15:0] wdata_s [4];
    logic        busy_o  [4];
    logic        ack_o   [4];
    logic [15:0] rdata_o [4];
    logic [15:0] out_o   [4];

    ram_ctrl_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) b0 ();
    ram_ctrl_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) b1 ();
    ram_ctrl_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) b2 ();
    ram_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) b3 ();

    ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(3)) u1 (.clk(clk), .reset(reset), .bus(b1));
    ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .WAIT_STATES(2)) u2 (.clk(clk), .reset(reset), .bus(b2));
    ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(1), .OUT_ADDR(8'h80))
        u3 (.clk(clk), .reset(reset), .bus(b3));

    assign b0.req = req_s[0]; assign b0.we = we_s[0];
    assign b0.addr = addr_s[0][3:0]; assign b0.wdata = wdata_s[0][7:0];
    assign b1.req = req_s[1]; assign b1.we = we_s[1];
    assign b1.addr = addr_s[1][3:0]; assign b1.wdata = wdata_s[1][7:0];
    assign b2.req = req_s[2]; assign b2.we = we_s[2];
    assign b2.addr = addr_s[2][3:0]; assign b2.wdata = wdata_s[2][7:0];
    assign b3.req = req_s[3]; assign b3.we = we_s[3];
    assign b3.addr = addr_s[3]; assign b3.wdata = wdata_s[3];

    assign busy_o[0] = b0.busy; assign ack_o[0] = b0.ack;
    assign rdata_o[0] = {8'h00, b0.rdata}; assign out_o[0] = {8'h00, b0.out_val};
    assign busy_o[1] = b1.busy; assign ack_o[1] = b1.ack;
    assign rdata_o[1] = {8'h00, b1.rdata}; assign out_o[1] = {8'h00, b1.out_val};
    assign busy_o[2] = b2.busy; assign ack_o[2] = b2.ack;
    assign rdata_o[2] = {8'h00, b2.rdata}; assign out_o[2] = {8'h00, b2.out_val};
    assign busy_o[3] = b3.busy; assign ack_o[3] = b3.ack;
    assign rdata_o[3] = b3.rdata; assign out_o[3] = b3.out_val;

    // instance configuration
    int          ws [4] = '{0, 3, 2, 1};
    logic [15:0] dm [4] = '{16'h00FF, 16'h00FF, 16'h00FF, 16'hFFFF};
    logic [7:0]  am [4] = '{8'h0F, 8'h0F, 8'h0F, 8'hFF};
    logic [7:0]  oa [4] = '{8'h0F, 8'h0F, 8'h0F, 8'h80};

    // reference model
    logic [15:0] mm  [4][256];
    bit          vld [4][256];
    logic [15:0] om  [4];
    logic [15:0] rm  [4];
    bit          rv  [4];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%h want=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            om[k] = '0;
            rm[k] = '0;
            rv[k] = 1'b1;
        end
    endtask

    // One transaction on instance k. After acceptance the inputs are
    // scrambled (operands must already be latched); with junk=1 a store
    // request to addr^1 is held during busy and must be ignored.
    task automatic do_op(input int k, input bit w, input logic [7:0] a,
                         input logic [15:0] d, input bit junk);
        int n;
        int wt;
        n  = 0;
        wt = ws[k];
        while (busy_o[k] !== 1'b0 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_before_req", k, 16'(busy_o[k]), 16'h0000);
        req_s[k] = 1'b1; we_s[k] = w; addr_s[k] = a; wdata_s[k] = d;
        @(posedge clk); #1;
        chk("busy_after_accept", k, 16'(busy_o[k]), 16'h0001);
        chk("ack_after_accept", k, 16'(ack_o[k]), 16'h0000);
        req_s[k]   = junk;
        we_s[k]    = junk ? 1'b1 : ~w;
        addr_s[k]  = (a ^ 8'h01) & am[k];
        wdata_s[k] = ~d & dm[k];
        for (int e = 1; e <= wt + 2; e++) begin
            @(posedge clk); #1;
            chk("ack_timing", k, 16'(ack_o[k]), (e == wt + 1) ? 16'h0001 : 16'h0000);
            chk("busy_timing", k, 16'(busy_o[k]), (e <= wt + 1) ? 16'h0001 : 16'h0000);
            if (e == wt + 1) begin
                if (w) begin
                    mm[k][a]  = d;
                    vld[k][a] = 1'b1;
                    if (a == oa[k]) om[k] = d;
                end else begin
                    rm[k] = mm[k][a];
                    rv[k] = vld[k][a];
                end
                if (rv[k]) chk("rdata_model", k, rdata_o[k], rm[k]);
                chk("out_val_model", k, out_o[k], om[k]);
            end
        end
        req_s[k] = 1'b0;
    endtask

    typedef struct {
        int          k;
        bit          w;
        logic [7:0]  a;
        logic [15:0] d;
        bit          junk;
        logic [15:0] er;
        logic [15:0] eo;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1, 1'b1, 8'h05, 16'h0011, 1'b0, 16'h0000, 16'h0000};
        tbl[1]  = '{0, 1'b1, 8'h0F, 16'h0003, 1'b0, 16'h0000, 16'h0003};
        tbl[2]  = '{0, 1'b0, 8'h0F, 16'h0000, 1'b0, 16'h0003, 16'h0003};
        tbl[3]  = '{0, 1'b1, 8'h03, 16'h0077, 1'b0, 16'h0003, 16'h0003};
        tbl[4]  = '{1, 1'b1, 8'h02, 16'h005A, 1'b0, 16'h0000, 16'h0000};
        tbl[5]  = '{1, 1'b0, 8'h02, 16'h0000, 1'b0, 16'h005A, 16'h0000};
        tbl[6]  = '{2, 1'b1, 8'h07, 16'h0033, 1'b0, 16'h0000, 16'h0000};
        tbl[7]  = '{2, 1'b1, 8'h06, 16'h0044, 1'b1, 16'h0000, 16'h0000};
        tbl[8]  = '{2, 1'b0, 8'h07, 16'h0000, 1'b0, 16'h0033, 16'h0000};
        tbl[9]  = '{2, 1'b0, 8'h06, 16'h0000, 1'b0, 16'h0044, 16'h0000};
        tbl[10] = '{3, 1'b1, 8'h80, 16'hBEEF, 1'b0, 16'h0000, 16'hBEEF};
        tbl[11] = '{3, 1'b0, 8'h80, 16'h0000, 1'b0, 16'hBEEF, 16'hBEEF};
        tbl[12] = '{3, 1'b1, 8'hFF, 16'h1234, 1'b0, 16'hBEEF, 16'hBEEF};
        tbl[13] = '{3, 1'b0, 8'hFF, 16'h0000, 1'b0, 16'h1234, 16'hBEEF};

        for (int k = 0; k < 4; k++) begin
            req_s[k] = 1'b0; we_s[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
            for (int i = 0; i < 256; i++) begin
                mm[k][i]  = '0;
                vld[k][i] = 1'b0;
            end
        end
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_busy", k, 16'(busy_o[k]), 16'h0000);
            chk("rst_ack", k, 16'(ack_o[k]), 16'h0000);
            chk("rst_rdata", k, rdata_o[k], 16'h0000);
            chk("rst_out_val", k, out_o[k], 16'h0000);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // directed table
        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].junk);
            chk("tbl_rdata", tbl[i].k, rdata_o[tbl[i].k], tbl[i].er);
            chk("tbl_out_val", tbl[i].k, out_o[tbl[i].k], tbl[i].eo);
        end

        // reset in the middle of a W=3 store of 0xAA to 0x5
        @(negedge clk);
        req_s[1] = 1'b1; we_s[1] = 1'b1; addr_s[1] = 8'h05; wdata_s[1] = 16'h00AA;
        @(posedge clk); #1;
        req_s[1] = 1'b0;
        chk("midrst_busy_pre", 1, 16'(busy_o[1]), 16'h0001);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("midrst_busy", k, 16'(busy_o[k]), 16'h0000);
            chk("midrst_ack", k, 16'(ack_o[k]), 16'h0000);
            chk("midrst_rdata", k, rdata_o[k], 16'h0000);
            chk("midrst_out_val", k, out_o[k], 16'h0000);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_op(1, 1'b0, 8'h05, 16'h0000, 1'b0);
        chk("midrst_mem_kept", 1, rdata_o[1], 16'h0011);
        do_op(3, 1'b0, 8'h80, 16'h0000, 1'b0);
        chk("midrst_mem3_kept", 3, rdata_o[3], 16'hBEEF);

        // randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            int          k;
            bit          w;
            bit          junk;
            logic [7:0]  a;
            logic [15:0] d;
            k    = int'($urandom_range(0, 3));
            w    = 1'($urandom_range(0, 1));
            junk = ($urandom_range(0, 3) == 0);
            a    = 8'($urandom) & am[k];
            d    = 16'($urandom) & dm[k];
            // bias toward the output-register address
            if ($urandom_range(0, 7) == 0) a = oa[k];
            do_op(k, w, a, d, junk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Parametrised single-port RAM with a request/acknowledge handshake, configurable wait states and a memory-mapped output register. It replaces the fixed 16×8 RAM on the SAP-2.0 memory bus. The control unit issues load/store requests (LDA, STA and successors), and writes to a designated address also drive the computer's `out_val` port. Width, depth and access latency are parameters, so the same block serves wider datapaths and slower memory models.

## Interface
- DATA_WIDTH, 8: data word width in bits.
- ADDR_WIDTH, 4: address width; depth = 2**ADDR_WIDTH words.
- WAIT_STATES, 0: extra cycles inserted between request acceptance and commit; range 0–15.
- OUT_ADDR, 2**ADDR_WIDTH-1: address whose writes also update `out_val`.

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  1  request strobe, sampled only in IDLE.
- we  in  1  1 = store, 0 = load; sampled with `req`.
- addr  in  ADDR_WIDTH  word address; sampled with `req`.
- wdata  in  DATA_WIDTH  store data; sampled with `req`.
- busy  out  1  high in every state except IDLE.
- ack  out  1  one-cycle completion pulse.
- rdata  out  DATA_WIDTH  load result; held until the next load completes.
- out_val  out  DATA_WIDTH  memory-mapped output register.

## Operation
- Storage array `mem[0:2**ADDR_WIDTH-1]` is the hierarchical preload target for `$readmemh`. Reset does not clear it.
- Reset values: state IDLE, busy 0, ack 0, rdata 0, out_val 0, wait counter 0.
- FSM states:
  - IDLE: on `req`=1 at an edge, latch `we`, `addr` and `wdata`, then go to WAIT (WAIT_STATES>0) or COMMIT (WAIT_STATES=0).
  - WAIT: counter loads WAIT_STATES-1 on entry and decrements each edge. At 0, go to COMMIT.
  - COMMIT: at the edge leaving COMMIT:
    - store: write the latched data to `mem[addr]`; if addr==OUT_ADDR, also load `out_val`.
    - load: capture `mem[addr]` into `rdata`.
    - then go to ACK.
  - ACK: `ack`=1 for exactly this cycle, then go to IDLE.
- Requests arriving outside IDLE are ignored (not queued). The requester holds `req` low or waits for `busy`=0.
- Latched operands are used throughout. Changing `addr`, `wdata` or `we` after acceptance has no effect.
- Loads from OUT_ADDR return `mem[OUT_ADDR]`, not a separate register. Stores to OUT_ADDR update both.
- `rdata` is unchanged by stores.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. A store that has not passed its COMMIT edge is dropped, and `mem` is unchanged.

## Timing
- Acceptance edge = T0. busy rises after T0.
- Commit edge = T0+WAIT_STATES+1.
- `ack` is high between edges T0+W+1 and T0+W+2. `rdata` and `out_val` are valid from T0+W+1 onward.
- `busy` falls after T0+W+2.
- Earliest next acceptance is edge T0+W+3; sustained throughput is one access per W+3 cycles.
- W=0: store accepted at T0 is visible in `mem` after T0+1, with ack over [T0+1, T0+2).
- Read-after-write to the same address in consecutive transactions returns the new data.
- No combinational path from inputs to outputs.

## Test plan
- Reset check: drive reset=0 mid-WAIT (W=3) on a store of 0xAA to 0x5 → busy=0, ack=0, out_val=0, mem[5] unchanged (preloaded 0x11).
- Basic store/load, W=0:
  - store 0x03 to 0xF → mem[15]=0x03 after T0+1, ack single pulse, out_val=0x03.
  - load 0xF → rdata=0x03.
- Wait states, W=3:
  - store 0x5A to 0x2 → ack exactly at cycle T0+4 (pulse between edges T0+4 and T0+5), busy high for 5 cycles.
  - load 0x2 → rdata=0x5A with the same latency.
- Ignored request: with W=2, assert req (store 0xFF to 0x7) while busy → mem[7] keeps its preload, only the first transaction acks.
- Operand latching: change addr/wdata the cycle after acceptance → write lands at the originally latched address with the originally latched data.
- Width sweep: DATA_WIDTH=16, ADDR_WIDTH=8, OUT_ADDR=0x80:
  - store 0xBEEF to 0x80 → out_val=0xBEEF.
  - load 0x80 → rdata=0xBEEF.
  - store to 0xFF → out_val unchanged.
